// File: rtl/sram_pkg.sv
// Shared types and defaults for the asynchronous SRAM burst controller.
package sram_pkg;

  // Controller phases; a read skips HOLD, TURN is the bus-turnaround gap.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    TURN
  } state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_LEN_W       = 4;
  localparam int DEF_TURN_CYCLES = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the ACCESS and TURN phases.
// It counts down to zero and holds there; done is high while the count is zero.
module sram_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load takes priority; otherwise decrement until zero.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous SRAM: wait states, incrementing
// bursts with address wrap, per-byte write enables and a turnaround gap.
// Every pad output is a flop so the strobes cannot glitch.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BE_W        = DATA_W / 8,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [BE_W-1:0]   byte_en,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] data_write,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] data_read,
  output logic              rdata_valid,
  output logic              ready,
  output logic [DATA_W-1:0] data_pins_out,
  input  logic [DATA_W-1:0] data_pins_in,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr_pins,
  output logic              CS,
  output logic              OE,
  output logic              WE,
  output logic [BE_W-1:0]   BE
);

  localparam int CNT_W = $clog2(max_int(WAIT_CYCLES, TURN_CYCLES) + 1);
  // The counter reaches zero during the last cycle of a phase, hence the -1.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  state_t           state;
  logic             dir;
  logic [LEN_W-1:0] remaining;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             last_word_end;

  // The last word ends when a read leaves ACCESS or a write leaves HOLD.
  assign last_word_end = (remaining == '0) &&
                         (((state == ACCESS) && cnt_done && (dir == DIR_RD)) ||
                          (state == HOLD));

  // Counter load: the ACCESS length while in SETUP, the TURN length on the way out.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = WAIT_LOAD;
    if (state == SETUP) begin
      cnt_load = 1'b1;
    end else if ((TURN_CYCLES > 0) && last_word_end) begin
      cnt_load = 1'b1;
      cnt_val  = TURN_LOAD;
    end
  end

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Sequencer; each transition also sets the registered pins for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      dir           <= DIR_RD;
      remaining     <= '0;
      ready         <= 1'b1;
      wdata_ack     <= 1'b0;
      rdata_valid   <= 1'b0;
      data_read     <= '0;
      addr_pins     <= '0;
      data_pins_out <= '0;
      data_oe       <= 1'b0;
      CS            <= 1'b1;
      OE            <= 1'b1;
      WE            <= 1'b1;
      BE            <= '1;
    end else begin
      wdata_ack   <= 1'b0;
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (write || read) begin
            // A simultaneous read request is dropped: write wins.
            dir       <= write ? DIR_WR : DIR_RD;
            remaining <= burst_len;
            addr_pins <= address;
            ready     <= 1'b0;
            CS        <= 1'b0;
            state     <= SETUP;
            if (write) begin
              data_pins_out <= data_write;
              data_oe       <= 1'b1;
              BE            <= ~byte_en;
              wdata_ack     <= 1'b1;
            end else begin
              data_oe <= 1'b0;
              BE      <= '0;
              OE      <= 1'b0;
            end
          end
        end
        SETUP: begin
          if (dir == DIR_WR) WE <= 1'b0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt_done) begin
            if (dir == DIR_WR) begin
              WE    <= 1'b1;
              state <= HOLD;
            end else begin
              data_read   <= data_pins_in;
              rdata_valid <= 1'b1;
              if (remaining != '0) begin
                // CS and OE stay low between words of a read burst.
                remaining <= remaining - 1'b1;
                addr_pins <= addr_pins + 1'b1;
                state     <= SETUP;
              end else begin
                CS    <= 1'b1;
                OE    <= 1'b1;
                BE    <= '1;
                ready <= (TURN_CYCLES == 0);
                state <= (TURN_CYCLES == 0) ? IDLE : TURN;
              end
            end
          end
        end
        HOLD: begin
          if (remaining != '0) begin
            // The edge entering SETUP is the capture edge of the next word.
            remaining     <= remaining - 1'b1;
            addr_pins     <= addr_pins + 1'b1;
            data_pins_out <= data_write;
            wdata_ack     <= 1'b1;
            state         <= SETUP;
          end else begin
            CS      <= 1'b1;
            data_oe <= 1'b0;
            BE      <= '1;
            ready   <= (TURN_CYCLES == 0);
            state   <= (TURN_CYCLES == 0) ? IDLE : TURN;
          end
        end
        TURN: begin
          if (cnt_done) begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          CS      <= 1'b1;
          OE      <= 1'b1;
          WE      <= 1'b1;
          data_oe <= 1'b0;
          ready   <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
